// File: rtl/reduction_gather_pipe.sv
// Two-stage valid/ready pipeline that gathers selected input elements per lane,
// optionally sums adjacent lane pairs, and counts output beats carrying range errors.
module reduction_gather_pipe #(
   parameter int DW_DATA = 8,
   parameter int NUM_IN  = 8,
   parameter int NUM_OUT = 4,
   parameter int SEL_IN  = 3,
   parameter int ERR_W   = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [DW_DATA*NUM_IN-1:0]      in_data,
   input  logic [SEL_IN*NUM_OUT-1:0]      in_sel,
   input  logic [NUM_OUT-1:0]             in_mask,
   input  logic                           in_mode,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [(DW_DATA+1)*NUM_OUT-1:0] out_data,
   output logic [NUM_OUT-1:0]             out_err,
   output logic [ERR_W-1:0]               err_cnt
);

   localparam int OW = DW_DATA + 1;

   logic                        s1_valid;
   logic [DW_DATA*NUM_OUT-1:0]  s1_op;
   logic [NUM_OUT-1:0]          s1_mask;
   logic [NUM_OUT-1:0]          s1_rng;
   logic                        s1_mode;

   logic                        load1;
   logic                        load2;

   logic [DW_DATA*NUM_OUT-1:0]  pick;
   logic [NUM_OUT-1:0]          rng;
   logic [DW_DATA-1:0]          op [NUM_OUT];
   logic [NUM_OUT-1:0]          flag;
   logic [OW*NUM_OUT-1:0]       res;
   logic [NUM_OUT-1:0]          res_err;

   assign load2    = s1_valid && (!s2_full() || out_ready);
   assign in_ready = !s1_valid || load2;
   assign load1    = in_valid && in_ready;

   function automatic logic s2_full();
      return out_valid;
   endfunction

   // Element select per lane; an out-of-range index matches no element and yields 0.
   always_comb begin
      pick = '0;
      rng  = '0;
      for (int unsigned k = 0; k < NUM_OUT; k++) begin
         rng[k] = 32'(in_sel[k*SEL_IN +: SEL_IN]) >= 32'(NUM_IN);
         for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (in_sel[k*SEL_IN +: SEL_IN] == SEL_IN'(i))
               pick[k*DW_DATA +: DW_DATA] = in_data[i*DW_DATA +: DW_DATA];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_op    <= '0;
         s1_mask  <= '0;
         s1_rng   <= '0;
         s1_mode  <= 1'b0;
      end else if (load1) begin
         s1_valid <= 1'b1;
         s1_op    <= pick;
         s1_mask  <= in_mask;
         s1_rng   <= rng;
         s1_mode  <= in_mode;
      end else if (load2) begin
         s1_valid <= 1'b0;
      end
   end

   always_comb begin
      res     = '0;
      res_err = '0;
      for (int unsigned k = 0; k < NUM_OUT; k++) begin
         op[k]   = (s1_mask[k] && !s1_rng[k]) ? s1_op[k*DW_DATA +: DW_DATA] : '0;
         flag[k] = s1_mask[k] && s1_rng[k];
      end
      if (!s1_mode) begin
         for (int unsigned k = 0; k < NUM_OUT; k++)
            res[k*OW +: OW] = {1'b0, op[k]};
         res_err = flag;
      end else begin
         for (int unsigned j = 0; j < NUM_OUT/2; j++) begin
            res[(2*j)*OW +: OW] = {1'b0, op[2*j]} + {1'b0, op[2*j+1]};
            res_err[2*j]        = flag[2*j] || flag[2*j+1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_err   <= '0;
      end else if (load2) begin
         out_valid <= 1'b1;
         out_data  <= res;
         out_err   <= res_err;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         err_cnt <= '0;
      else if (out_valid && out_ready && (|out_err) && (err_cnt != '1))
         err_cnt <= err_cnt + ERR_W'(1);
   end

endmodule
